// File: rtl/result_src_mux.sv
// Write-back result selector: combinational ALU/memory/PC+4 mux plus a registered copy with valid and illegal-select status.
// Optional macro RESULT_SRC_IMM_EN adds an imm_ext port that select 11 picks (lui/auipc) instead of flagging it illegal.
module result_src_mux #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] read_data,
    input  logic [WIDTH-1:0] pc_plus4,
`ifdef RESULT_SRC_IMM_EN
    input  logic [WIDTH-1:0] imm_ext,
`endif
    input  logic [1:0]       result_src,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_q,
    output logic             out_valid,
    output logic             sel_illegal,
    output logic             illegal_sticky,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [WIDTH-1:0] capt_q, capt_d;
    logic             valid_q, valid_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Unselected sources never reach result, so X/Z on them stays contained.
    always_comb begin
        result = '0;
        case (result_src)
            2'b00:   result = alu_result;
            2'b01:   result = read_data;
            2'b10:   result = pc_plus4;
`ifdef RESULT_SRC_IMM_EN
            2'b11:   result = imm_ext;
`endif
            default: result = '0;
        endcase
    end

`ifdef RESULT_SRC_IMM_EN
    assign sel_illegal = 1'b0;
`else
    assign sel_illegal = in_valid & (result_src == 2'b11);
`endif

    always_comb begin
        capt_d   = capt_q;
        valid_d  = in_valid;
        sticky_d = sticky_q | sel_illegal;
        cnt_d    = cnt_q;
        if (in_valid) begin
            capt_d = result;
        end
        // Counter saturates at all-ones rather than wrapping.
        if (sel_illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            capt_q   <= '0;
            valid_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            capt_q   <= capt_d;
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_q       = capt_q;
    assign out_valid      = valid_q;
    assign illegal_sticky = sticky_q;
    assign illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_result_src_mux.sv
// Directed bench for result_src_mux: a per-cycle reference model plus literal checks.
// A CNT_W=2 instance shares the stimulus to exercise counter saturation quickly.
module tb_result_src_mux;

`ifdef RESULT_SRC_IMM_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result, read_data, pc_plus4, imm_ext;
    logic [1:0]  result_src;
    logic        in_valid;

    logic [31:0] result, result_q;
    logic        out_valid, sel_illegal, illegal_sticky;
    logic [7:0]  illegal_cnt;

    logic [31:0] result_s, result_q_s;
    logic        out_valid_s, sel_illegal_s, illegal_sticky_s;
    logic [1:0]  illegal_cnt_s;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    result_src_mux #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
`ifdef RESULT_SRC_IMM_EN
        .imm_ext(imm_ext),
`endif
        .result_src(result_src), .in_valid(in_valid),
        .result(result), .result_q(result_q), .out_valid(out_valid),
        .sel_illegal(sel_illegal), .illegal_sticky(illegal_sticky), .illegal_cnt(illegal_cnt)
    );

    result_src_mux #(.WIDTH(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .alu_result(alu_result), .read_data(read_data), .pc_plus4(pc_plus4),
`ifdef RESULT_SRC_IMM_EN
        .imm_ext(imm_ext),
`endif
        .result_src(result_src), .in_valid(in_valid),
        .result(result_s), .result_q(result_q_s), .out_valid(out_valid_s),
        .sel_illegal(sel_illegal_s), .illegal_sticky(illegal_sticky_s), .illegal_cnt(illegal_cnt_s)
    );

    // Reference model: select by table lookup, counters as plain saturating integers.
    logic [31:0] m_q;
    logic        m_valid;
    logic        m_sticky;
    int unsigned m_cnt, m_cnt_s;

    function automatic logic [31:0] m_result();
        logic [31:0] srcs [4];
        srcs[0] = alu_result;
        srcs[1] = read_data;
        srcs[2] = pc_plus4;
        srcs[3] = FEAT ? imm_ext : 32'h0;
        if ($isunknown(result_src)) return 32'h0;
        return srcs[result_src];
    endfunction

    function automatic logic m_illegal();
        return !FEAT && (in_valid === 1'b1) && (result_src === 2'b11);
    endfunction

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            m_q      <= 32'h0;
            m_valid  <= 1'b0;
            m_sticky <= 1'b0;
            m_cnt    <= 0;
            m_cnt_s  <= 0;
        end else begin
            if (in_valid) m_q <= m_result();
            m_valid <= in_valid;
            if (m_illegal()) begin
                m_sticky <= 1'b1;
                m_cnt    <= (m_cnt   < 255) ? m_cnt + 1   : 255;
                m_cnt_s  <= (m_cnt_s < 3)   ? m_cnt_s + 1 : 3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
        else passes++;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.result",         result,             m_result());
            chk("m.sel_illegal",    {31'h0, sel_illegal}, {31'h0, m_illegal()});
            chk("m.result_q",       result_q,           m_q);
            chk("m.out_valid",      {31'h0, out_valid}, {31'h0, m_valid});
            chk("m.sticky",         {31'h0, illegal_sticky}, {31'h0, m_sticky});
            chk("m.cnt",            {24'h0, illegal_cnt}, m_cnt);
            chk("m.cnt_s",          {30'h0, illegal_cnt_s}, m_cnt_s);
            chk("m.sticky_s",       {31'h0, illegal_sticky_s}, {31'h0, m_sticky});
            chk("m.result_q_s",     result_q_s,         m_q);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  v_src [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
    logic        v_vld [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] v_alu [8] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004,
                               32'h5555_0005, 32'h6666_0006, 32'h7777_0007, 32'h8888_0008};

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        alu_result = 32'h0000_1234;
        read_data  = 32'hDEAD_BEEF;
        pc_plus4   = 32'h0000_0008;
        imm_ext    = 32'hABCD_E000;

        // Combinational select before any clock edge.
        result_src = 2'b00; #1 chk("comb.alu", result, 32'h0000_1234);
        result_src = 2'b01; #1 chk("comb.mem", result, 32'hDEAD_BEEF);
        result_src = 2'b10; #1 chk("comb.pc4", result, 32'h0000_0008);

        // Reset held for two edges with a valid memory select.
        result_src = 2'b01;
        tick(); tick();
        chk("rst.result_q",  result_q, 32'h0);
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.cnt",       {24'h0, illegal_cnt}, 32'h0);
        cmp_en = 1'b1;

        rst_n = 1'b1;
        tick();
        chk("rel.result_q",  result_q, 32'hDEAD_BEEF);
        chk("rel.out_valid", {31'h0, out_valid}, 32'h1);

        // Valid gating.
        result_src = 2'b00;
        tick();
        chk("cap.result_q", result_q, 32'h0000_1234);
        in_valid = 1'b0; result_src = 2'b10;
        #1 chk("gate.comb", result, 32'h0000_0008);
        tick();
        chk("gate.result_q",  result_q, 32'h0000_1234);
        chk("gate.out_valid", {31'h0, out_valid}, 32'h0);

        // X on an unselected source must not leak into result.
        result_src = 2'b00; read_data = 32'hxxxx_xxxx;
        #1 chk("x.result", result, 32'h0000_1234);
        tick();
        read_data = 32'hDEAD_BEEF;

`ifdef RESULT_SRC_IMM_EN
        in_valid = 1'b1; result_src = 2'b11;
        #1 chk("imm.comb", result, 32'hABCD_E000);
        chk("imm.sel_illegal", {31'h0, sel_illegal}, 32'h0);
        tick();
        chk("imm.result_q", result_q, 32'hABCD_E000);
        chk("imm.cnt",      {24'h0, illegal_cnt}, 32'h0);
        chk("imm.sticky",   {31'h0, illegal_sticky}, 32'h0);
`else
        in_valid = 1'b1; result_src = 2'b11;
        #1 chk("ill.comb", result, 32'h0);
        chk("ill.sel_illegal", {31'h0, sel_illegal}, 32'h1);
        tick(); tick(); tick();
        chk("ill.result_q",  result_q, 32'h0);
        chk("ill.out_valid", {31'h0, out_valid}, 32'h1);
        chk("ill.sticky",    {31'h0, illegal_sticky}, 32'h1);
        chk("ill.cnt",       {24'h0, illegal_cnt}, 32'd3);
        tick(); tick(); tick();
        chk("sat.cnt_s", {30'h0, illegal_cnt_s}, 32'd3);
        chk("sat.cnt",   {24'h0, illegal_cnt}, 32'd6);

        // Illegal select without in_valid is not counted.
        in_valid = 1'b0;
        tick();
        chk("ill.novalid_cnt", {24'h0, illegal_cnt}, 32'd6);
        chk("ill.novalid_sel", {31'h0, sel_illegal}, 32'h0);

        // Drive the 8-bit counter to its ceiling.
        in_valid = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        chk("sat.cnt8", {24'h0, illegal_cnt}, 32'd255);
`endif

        // Reset mid-stream while an illegal/valid select is active.
        rst_n = 1'b0; in_valid = 1'b1; result_src = 2'b11;
        tick();
        chk("mrst.cnt",      {24'h0, illegal_cnt}, 32'h0);
        chk("mrst.cnt_s",    {30'h0, illegal_cnt_s}, 32'h0);
        chk("mrst.sticky",   {31'h0, illegal_sticky}, 32'h0);
        chk("mrst.result_q", result_q, 32'h0);
        chk("mrst.out_valid",{31'h0, out_valid}, 32'h0);
        result_src = 2'b10;
        #1 chk("mrst.comb", result, 32'h0000_0008);
        rst_n = 1'b1;

        // Mixed traffic checked cycle by cycle against the model.
        for (int i = 0; i < 8; i++) begin
            result_src = v_src[i];
            in_valid   = v_vld[i];
            alu_result = v_alu[i];
            read_data  = ~v_alu[i];
            pc_plus4   = v_alu[i] + 32'd4;
            tick();
        end
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/result_src_mux.md
Name: result_src_mux

Overview:
- Write-back result selector for the single-cycle RISC-V datapath.
- Picks the register-file write data from the ALU result, the data-memory read data or PC+4, under the 2-bit control `result_src` from the control unit.
- Provides a zero-latency combinational result for the datapath and a one-cycle registered copy with valid and illegal-select status for pipelined or trace use.

Parameters:
- WIDTH, 32, data width of all data inputs and result outputs.
- CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- alu_result  input  WIDTH  ALU output (arith/logic, address).
- read_data  input  WIDTH  data-memory read data (loads).
- pc_plus4  input  WIDTH  PC+4 (jal/jalr link value).
- result_src  input  2  select: 00 ALU, 01 memory, 10 PC+4, 11 reserved.
- in_valid  input  1  current select/data are meaningful this cycle.
- result  output  WIDTH  combinational selected value.
- result_q  output  WIDTH  registered selected value.
- out_valid  output  1  result_q holds a value captured with in_valid=1.
- sel_illegal  output  1  combinational: in_valid=1 and result_src is reserved.
- illegal_sticky  output  1  set once any illegal select is captured; cleared only by reset.
- illegal_cnt  output  CNT_W  count of cycles with an illegal select captured; saturates.

Behaviour:
- Combinational path:
  - result = alu_result when result_src=00.
  - result = read_data when result_src=01.
  - result = pc_plus4 when result_src=10.
  - result = all-zeros when result_src=11 (feature off).
  - No dependence on clk, rst_n or in_valid; zero latency.
- Inputs X/Z on unselected data sources must not propagate to result.
- Register stage, on rising clk:
  - rst_n=0: result_q=0, out_valid=0, illegal_sticky=0, illegal_cnt=0. Reset wins over all other activity in the same cycle.
  - Else if in_valid=1: result_q<=result, out_valid<=1.
  - Else: result_q holds its previous value, out_valid<=0.
  - Latency input to result_q is exactly 1 cycle.
- Illegal select tracking:
  - sel_illegal = in_valid & (result_src==11), combinational. With the feature enabled it is tied 0.
  - On a clock edge with sel_illegal=1 and rst_n=1: illegal_sticky<=1; illegal_cnt increments.
  - illegal_cnt stops at 2^CNT_W-1 and does not wrap.
  - result_q captures all-zeros for an illegal select and out_valid still asserts, so downstream sees a defined value.
- Select changes mid-cycle are reflected on result immediately. result_q samples only the value present at the edge.
- Reset asserted mid-stream clears the registered state on that edge. The combinational result keeps following its inputs during reset.

Optional Feature:
- Macro RESULT_SRC_IMM_EN.
- Defined:
  - Adds input port imm_ext (WIDTH) after pc_plus4.
  - result_src=11 selects imm_ext (lui/auipc support) and is legal.
  - sel_illegal is constant 0; illegal_sticky and illegal_cnt stay 0.
- Undefined:
  - No imm_ext port.
  - 11 yields zero and is flagged illegal, as above.

Test Plan:
- Combinational select:
  - Stimulus: alu_result=0x0000_1234, read_data=0xDEAD_BEEF, pc_plus4=0x0000_0008; step result_src 00, 01, 10.
  - Response: result = 0x0000_1234, 0xDEAD_BEEF, 0x0000_0008 with no clock edge needed.
- Reset:
  - Stimulus: rst_n=0 for 2 edges with in_valid=1, src=01.
  - Response: result_q=0, out_valid=0, illegal_cnt=0. First edge after release gives result_q=0xDEAD_BEEF, out_valid=1.
- Valid gating:
  - Stimulus: capture src=00 (0x1234), then in_valid=0 with src=10.
  - Response: result_q stays 0x0000_1234, out_valid=0; result shows 0x0000_0008 combinationally.
- Illegal select (feature off):
  - Stimulus: src=11, in_valid=1 for 3 edges.
  - Response: result=0, sel_illegal=1, result_q=0, illegal_sticky=1, illegal_cnt=3.
- Saturation:
  - Stimulus: CNT_W=2, 6 illegal edges.
  - Response: illegal_cnt=3 and holds. Reset clears it to 0 and the sticky bit to 0.
- Feature on (RESULT_SRC_IMM_EN):
  - Stimulus: imm_ext=0xABCD_E000, src=11, in_valid=1.
  - Response: result=0xABCD_E000, result_q=0xABCD_E000 next edge, sel_illegal=0, illegal_cnt=0.
